bk_pipe_addsub: RTL and testbench

// - Pipelined 32-bit adder/subtractor. Consumes operands, produces per-bit generate/propagate,
//   and drives brent_kung_generator. It then consumes the returned carry vector to form the sum and ALU flags.
// - Front end (PG) and back end (sum/flags) around the prefix carry network.
// - Valid/ready streaming on both sides; full throughput; sits between ALU operand mux and result writeback.

---
 rtl/bk_pipe_addsub.sv | 231 +++++++++++++++++++++++
 tb/tb_bk_pipe_addsub.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_pipe_addsub.sv
// Pipelined 32-bit adder/subtractor around a Brent-Kung carry network, valid/ready on both sides.
// Define BK_PIPE_CARRY_REG_EN to register the carry vector (latency 3 instead of 2).

module brent_kung_generator (
  input  logic [31:0] g_i,
  input  logic [31:0] p_i,
  output logic [31:0] carry_o
);

  // carry_o[i] is the group generate of bits [i:0]
  function automatic logic [31:0] bk_prefix(input logic [31:0] g, input logic [31:0] p);
    logic [31:0] gg;
    logic [31:0] pp;
    logic [4:0]  j;
    gg = g;
    pp = p;
    j  = '0;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          j     = 5'(i - (1 << l));
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
    // down-sweep fills the remaining prefixes from the tree spine
    for (int l = 3; l >= 0; l--) begin
      for (int i = 0; i < 32; i++) begin
        if ((i >= (3 * (1 << l)) - 1) && (((i + 1) % (1 << (l + 1))) == (1 << l))) begin
          j     = 5'(i - (1 << l));
          gg[i] = gg[i] | (pp[i] & gg[j]);
          pp[i] = pp[i] & pp[j];
        end
      end
    end
    return gg;
  endfunction

  assign carry_o = bk_prefix(g_i, p_i);

endmodule

module bk_pipe_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] out_tag
);

  if (WIDTH != 32) begin : g_bad_width
    $error("bk_pipe_addsub: WIDTH must be 32, carry network is fixed width");
  end

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;

  // cin enters as a generate on bit 0 so carry[0] already includes it
  assign bx  = sub ? ~b : b;
  assign p_d = a ^ bx;
  always_comb begin
    g_d    = a & bx;
    g_d[0] = g_d[0] | (p_d[0] & sub);
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_p_q;
  logic [WIDTH-1:0] s1_g_q;
  logic             s1_cin_q;
  logic             s1_a31_q;
  logic             s1_b31_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_adv;
  logic             out_adv;
  logic [WIDTH-1:0] carry;

  assign out_adv  = !out_valid || out_ready;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_a31_q   <= 1'b0;
      s1_b31_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_p_q   <= p_d;
        s1_g_q   <= g_d;
        s1_cin_q <= sub;
        s1_a31_q <= a[WIDTH-1];
        s1_b31_q <= bx[WIDTH-1];
        s1_tag_q <= in_tag;
      end
    end
  end

  brent_kung_generator u_bk (
    .g_i     (s1_g_q),
    .p_i     (s1_p_q),
    .carry_o (carry)
  );

  // back-end operands: either straight from stage 1 or from the carry register stage
  logic             be_valid;
  logic [WIDTH-1:0] be_carry;
  logic [WIDTH-1:0] be_p;
  logic             be_cin;
  logic             be_a31;
  logic             be_b31;
  logic [TAG_W-1:0] be_tag;

`ifdef BK_PIPE_CARRY_REG_EN
  logic             c_valid_q;
  logic [WIDTH-1:0] c_carry_q;
  logic [WIDTH-1:0] c_p_q;
  logic             c_cin_q;
  logic             c_a31_q;
  logic             c_b31_q;
  logic [TAG_W-1:0] c_tag_q;
  logic             c_adv;

  assign c_adv  = !c_valid_q || out_adv;
  assign s1_adv = !s1_valid_q || c_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid_q <= 1'b0;
      c_carry_q <= '0;
      c_p_q     <= '0;
      c_cin_q   <= 1'b0;
      c_a31_q   <= 1'b0;
      c_b31_q   <= 1'b0;
      c_tag_q   <= '0;
    end else if (c_adv) begin
      c_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        c_carry_q <= carry;
        c_p_q     <= s1_p_q;
        c_cin_q   <= s1_cin_q;
        c_a31_q   <= s1_a31_q;
        c_b31_q   <= s1_b31_q;
        c_tag_q   <= s1_tag_q;
      end
    end
  end

  assign be_valid = c_valid_q;
  assign be_carry = c_carry_q;
  assign be_p     = c_p_q;
  assign be_cin   = c_cin_q;
  assign be_a31   = c_a31_q;
  assign be_b31   = c_b31_q;
  assign be_tag   = c_tag_q;
`else
  assign s1_adv   = !s1_valid_q || out_adv;
  assign be_valid = s1_valid_q;
  assign be_carry = carry;
  assign be_p     = s1_p_q;
  assign be_cin   = s1_cin_q;
  assign be_a31   = s1_a31_q;
  assign be_b31   = s1_b31_q;
  assign be_tag   = s1_tag_q;
`endif

  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  assign sum_d = be_p ^ {be_carry[WIDTH-2:0], be_cin};
  assign ovf_d = (be_a31 == be_b31) && (sum_d[WIDTH-1] != be_a31);

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic [TAG_W-1:0] tag_q;

  // results only overwrite on a valid move, so outputs hold while invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      tag_q       <= '0;
    end else if (out_adv) begin
      out_valid_q <= be_valid;
      if (be_valid) begin
        sum_q  <= sum_d;
        cout_q <= be_carry[WIDTH-1];
        ovf_q  <= ovf_d;
        zero_q <= ~|sum_d;
        neg_q  <= sum_d[WIDTH-1];
        tag_q  <= be_tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_bk_pipe_addsub.sv
// Randomized scoreboard bench for bk_pipe_addsub; latency follows BK_PIPE_CARRY_REG_EN.
module tb_bk_pipe_addsub;

`ifdef BK_PIPE_CARRY_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout, ovf, zero, neg;
  logic [3:0]  out_tag;

  bk_pipe_addsub #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    res_t       m;
    res_t       lit;
    bit         lit_en;
    logic [3:0] tag;
    int         acc_cyc;
    bit         lat_chk;
  } ent_t;

  ent_t q[$];
  ent_t mon_e;
  ent_t new_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   head_seen = 0;
  bit   lit_en_g = 0;
  res_t lit_g;
  bit   lat_g = 0;
  bit   rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on 64-bit values
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint ux, uy, sx, sy, ur, sr;
    res_t   r;
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    sx = longint'({{32{x[31]}}, x});
    sy = longint'({{32{y[31]}}, y});
    ur = s ? ux - uy : ux + uy;
    sr = s ? sx - sy : sx + sy;
    r.sum  = ur[31:0];
    r.cout = s ? (x >= y) : (ur >= 64'sd4294967296);
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.zero = (r.sum == 32'd0);
    r.neg  = r.sum[31];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: compare head of queue whenever a result is presented
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      head_seen = 0;
    end else begin
      if (!out_valid || out_ready) chk("in_ready_free", 64'(in_ready), 64'(1));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got out_valid=1 tag %0d, required no pending op", out_tag);
        end else begin
          mon_e = q[0];
          chk("sum",  64'(sum),     64'(mon_e.m.sum));
          chk("cout", 64'(cout),    64'(mon_e.m.cout));
          chk("ovf",  64'(ovf),     64'(mon_e.m.ovf));
          chk("zero", 64'(zero),    64'(mon_e.m.zero));
          chk("neg",  64'(neg),     64'(mon_e.m.neg));
          chk("tag",  64'(out_tag), 64'(mon_e.tag));
          if (mon_e.lit_en) begin
            chk("lit_sum",  64'(sum),  64'(mon_e.lit.sum));
            chk("lit_cout", 64'(cout), 64'(mon_e.lit.cout));
            chk("lit_ovf",  64'(ovf),  64'(mon_e.lit.ovf));
            chk("lit_zero", 64'(zero), 64'(mon_e.lit.zero));
            chk("lit_neg",  64'(neg),  64'(mon_e.lit.neg));
          end
          if (!head_seen && mon_e.lat_chk)
            chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(LAT));
          head_seen = 1;
          if (out_ready) begin
            void'(q.pop_front());
            head_seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        new_e.m       = model(a, b, sub);
        new_e.lit     = lit_g;
        new_e.lit_en  = lit_en_g;
        new_e.tag     = in_tag;
        new_e.acc_cyc = cyc;
        new_e.lat_chk = lat_g;
        q.push_back(new_e);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [3:0] t);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    in_tag = t;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_en_g = 0;
  endtask

  task automatic drive_lit(input logic [31:0] x, input logic [31:0] y, input logic s,
                           input logic [3:0] t, input logic [31:0] es, input logic ec,
                           input logic eo, input logic ez, input logic en);
    lit_g.sum  = es;
    lit_g.cout = ec;
    lit_g.ovf  = eo;
    lit_g.zero = ez;
    lit_g.neg  = en;
    lit_en_g   = 1;
    drive_op(x, y, s, t);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    chk("drain_done", 64'(done), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum",       64'(sum),       64'(0));
    chk("rst_flags",     64'({cout, ovf, zero, neg}), 64'(0));
    chk("rst_tag",       64'(out_tag),   64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed corner cases with literal expectations
    drive_lit(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_lit(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd2, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    drive_lit(32'h0000_0005, 32'h0000_0007, 1'b1, 4'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_lit(32'h0000_0007, 32'h0000_0005, 1'b1, 4'd4, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_lit(32'h8000_0000, 32'h0000_0001, 1'b1, 4'd5, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // 8 back-to-back ops with latency check
    lat_g = 1;
    for (int i = 0; i < 8; i++) drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i));
    lat_g = 0;
    drain();

    // Mid-stream stall of 5 cycles
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("in_ready_stalled", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 12; i++) drive_op(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'(i));
    drain();

    // Random traffic with random backpressure
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive_op(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with ops in flight
    out_ready = 1'b0;
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 4'd9);
    drive_op(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 4'd10);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_in_ready",  64'(in_ready),  64'(1));
    chk("async_rst_sum",       64'(sum),       64'(0));
    chk("async_rst_tag",       64'(out_tag),   64'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    lat_g = 1;
    drive_lit(32'h0000_0007, 32'h0000_0005, 1'b1, 4'd6, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
    lat_g = 0;
    drain();

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
